// File: rtl/alu_seq.sv
// Multi-cycle unsigned ALU: single-cycle ADD/SUB, shift-add MUL and restoring DIV over WIDTH iterations.
// Operands are latched on start; results are registered and held until the next done pulse.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       opcode,
  input  logic [WIDTH-1:0] inbus_a,
  input  logic [WIDTH-1:0] inbus_b,
  output logic [WIDTH-1:0] outbus,
  output logic [WIDTH-1:0] outbus_hi,
  output logic             carry,
  output logic             div_zero,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  state_t           state, next_state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic [CW-1:0]    cnt;
  logic             load, step, finish;

  logic [WIDTH:0]   add_res, sub_res, mul_sum, div_trial, div_diff;
  logic [WIDTH-1:0] mul_addend;

  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = CALC;
        end
      end
      CALC: begin
        if (op_q == OP_ADD || op_q == OP_SUB ||
            (op_q == OP_DIV && b_q == '0) || cnt == CW'(WIDTH)) begin
          finish     = 1'b1;
          next_state = FIN;
        end else begin
          step = 1'b1;
        end
      end
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state == CALC);
  assign done = (state == FIN);

  // acc_lo holds the multiplier (MUL) or the dividend/quotient (DIV); acc_hi the partial product or remainder.
  assign add_res    = {1'b0, a_q} + {1'b0, b_q};
  assign sub_res    = {1'b0, a_q} - {1'b0, b_q};
  assign mul_addend = acc_lo[0] ? a_q : '0;
  assign mul_sum    = {1'b0, acc_hi} + {1'b0, mul_addend};
  assign div_trial  = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff   = div_trial - {1'b0, b_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      op_q      <= OP_ADD;
      a_q       <= '0;
      b_q       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      cnt       <= '0;
      outbus    <= '0;
      outbus_hi <= '0;
      carry     <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      state <= next_state;
      if (load) begin
        op_q   <= opcode;
        a_q    <= inbus_a;
        b_q    <= inbus_b;
        cnt    <= '0;
        acc_hi <= '0;
        acc_lo <= (opcode == OP_MUL) ? inbus_b : inbus_a;
      end
      if (step) begin
        cnt <= cnt + CW'(1);
        if (op_q == OP_MUL) begin
          {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
          acc_hi <= div_diff[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi <= div_trial[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
        end
      end
      if (finish) begin
        div_zero <= 1'b0;
        case (op_q)
          OP_ADD: begin
            outbus    <= add_res[WIDTH-1:0];
            outbus_hi <= '0;
            carry     <= add_res[WIDTH];
          end
          OP_SUB: begin
            outbus    <= sub_res[WIDTH-1:0];
            outbus_hi <= '0;
            carry     <= sub_res[WIDTH];
          end
          OP_MUL: begin
            outbus    <= acc_lo;
            outbus_hi <= acc_hi;
            carry     <= 1'b0;
          end
          default: begin
            carry <= 1'b0;
            if (b_q == '0) begin
              outbus    <= '1;
              outbus_hi <= a_q;
              div_zero  <= 1'b1;
            end else begin
              outbus    <= acc_lo;
              outbus_hi <= acc_hi;
            end
          end
        endcase
      end
    end
  end

endmodule
